vpa_e_responder: RTL and testbench
==================================

// Module: vpa_e_responder
// PURPOSE
//  Target side of the 68000 synchronous (VPA/VMA/E) peripheral cycle on the Amiga-side bus.
//  Decodes a 4 KB window, asserts VPA, waits for the master's VMA and one full E high phase,
//  and transfers one byte on E falling. Backs a small 8-bit register file with a CIA-style
//  down-counter. Used as a bench/on-board peripheral that exercises the accelerator's E-cycle path.
// PARAMETERS
//  BASE_ADDR  12'hBFE  match value for A[23:12]
//  LANE       1        byte lane: 1 = odd/low byte (LDS, D[7:0]), 0 = even/high byte (UDS, D[15:8])
// PORTS
//  CLK7M   in   1   7.09 MHz system clock; all state changes on rising edge
//  RESET   in   1   asynchronous, active-low reset
//  AS      in   1   address strobe, active low
//  UDS     in   1   upper data strobe, active low
//  LDS     in   1   lower data strobe, active low
//  RW00    in   1   1 = read, 0 = write
//  A       in   23  address A[23:1]
//  DIN     in   16  data bus in
//  DOUT    out  16  read data; selected byte replicated on both lanes
//  DOE     out  1   data output enable, active high
//  VMA     in   1   valid memory address from master, active low
//  E       in   1   E clock from master, synchronous to CLK7M
//  VPA     out  1   valid peripheral address, active low
//  INT_n   out  1   interrupt request, active low
// BEHAVIOUR
//  Reset: VPA=1, DOE=0, DOUT=0, INT_n=1, FSM=IDLE, all registers 0, E_D=0.
//  HIT = ~AS & (A[23:12]==BASE_ADDR) & (LANE ? ~LDS : ~UDS). Register index = A[4:1].
//  EFALL = E_D & ~E, where E_D is E registered on CLK7M.
//  FSM (one transition per CLK7M):
//   IDLE   : HIT -> ASSERT (VPA=0 from next edge).
//   ASSERT : ~VMA -> WAITE.
//   WAITE  : E==1 -> XFER (read data captured into DOUT on this edge).
//   XFER   : EFALL -> DONE; the write or read side effect commits on this edge only.
//   DONE   : VPA=1 from this edge; AS==1 -> IDLE.
//  AS==1 in ASSERT/WAITE/XFER: abort to IDLE, VPA=1, no write, no read side effect.
//  VPA is low only in ASSERT/WAITE/XFER. It is released on the first edge after E falls.
//  DOE = RW00 & ~AS & state in {WAITE, XFER, DONE}.
//  Registers (8-bit): 0-3 scratch R/W; 4 TALO, 5 TAHI latch R/W (reads return the counter);
//   13 ICR: read returns {IR, 6'b0, TAF} and clears TAF; write bit7=1 sets mask bits[0], bit7=0 clears them;
//   14 CRA: bit0 START, bit3 ONESHOT. Unmapped indices read 8'h00; writes to them are ignored.
//  Writing TAHI while START=0 loads counter <= {TAHI,TALO}.
//  Timer: decrement on each EFALL while START=1. Counter==0 at EFALL -> reload from latch,
//   set TAF; if ONESHOT, clear START. Simultaneous ICR read and underflow: TAF stays 1.
//  INT_n = ~(TAF & MASK0), registered.
// CONFIGURATION
//  VPA_TIMER_EN defined: timer, TALO/TAHI/ICR/CRA and INT_n as above.
//  VPA_TIMER_EN undefined: indices 4,5,13,14 become plain scratch R/W; INT_n tied 1; no counter logic.
// STRUCTURE
//  Package tf_bus_pkg: FSM state enum (IDLE, ASSERT, WAITE, XFER, DONE); register index
//   constants (REG_TALO=4, REG_TAHI=5, REG_ICR=13, REG_CRA=14); ICR/CRA bit positions.
//  Sub-module vpa_timer (counter, latch, START/ONESHOT/TAF, INT_n). Instantiated only under VPA_TIMER_EN.
// TESTING
//  1 Write 8'h5A to idx 0 at 0xBFE001 -> VPA low until the edge after E falls; read back 8'h5A with DOE=1.
//  2 Master holds VMA high for 20 clocks -> VPA stays low, no write; then VMA low -> cycle completes on the next E fall.
//  3 AS rises in WAITE -> FSM returns to IDLE, VPA=1, idx 0 unchanged.
//  4 A[23:12]=12'hBFD or LDS high (LANE=1) -> VPA stays high and DOE stays 0.
//  5 [TIMER_EN] TALO=2, TAHI=0, ICR=8'h81, CRA=8'h09 -> INT_n low after 3 E falls, START=0; ICR read returns 8'h81,
//    then INT_n high and the next ICR read returns 8'h00.
//  6 Assert RESET mid-XFER -> VPA=1, DOE=0, INT_n=1, all registers 0 asynchronously.

Source files
------------

// File: rtl/tf_bus_pkg.sv
// Shared types and constants for the VPA/E peripheral responder.
package tf_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASSERT = 3'd1,
    WAITE  = 3'd2,
    XFER   = 3'd3,
    DONE   = 3'd4
  } bus_state_t;

  localparam logic [3:0] REG_TALO = 4'd4;
  localparam logic [3:0] REG_TAHI = 4'd5;
  localparam logic [3:0] REG_ICR  = 4'd13;
  localparam logic [3:0] REG_CRA  = 4'd14;

  localparam int ICR_TA_BIT      = 0;  // TAF on read, mask bit on write
  localparam int ICR_IR_BIT      = 7;  // IR on read, set/clear select on write
  localparam int CRA_START_BIT   = 0;
  localparam int CRA_ONESHOT_BIT = 3;

  // Pick the byte lane this peripheral lives on (1 = D[7:0], 0 = D[15:8]).
  function automatic logic [7:0] lane_byte(input logic [15:0] d, input bit lane);
    return lane ? d[7:0] : d[15:8];
  endfunction

endpackage

// File: rtl/vpa_timer.sv
// vpa_timer: CIA-style 16-bit down-counter with latch, START/ONESHOT control,
// underflow flag TAF, interrupt mask and registered active-low interrupt.
module vpa_timer
  import tf_bus_pkg::*;
(
  input  logic       CLK7M,
  input  logic       RESET,
  input  logic       efall,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [3:0] idx,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       INT_n
);

  logic [7:0]  talo, tahi;
  logic [15:0] counter;
  logic        start, oneshot, taf, mask;
  logic        underflow;

  assign underflow = efall & start & (counter == 16'd0);

  // Latch, counter, control and flag state; counting is paced by E falling edges.
  always_ff @(posedge CLK7M or negedge RESET) begin
    if (!RESET) begin
      talo    <= '0;
      tahi    <= '0;
      counter <= '0;
      start   <= 1'b0;
      oneshot <= 1'b0;
      taf     <= 1'b0;
      mask    <= 1'b0;
      INT_n   <= 1'b1;
    end else begin
      if (wr_en && idx == REG_TALO) talo <= wdata;
      if (wr_en && idx == REG_TAHI) tahi <= wdata;

      // A stopped timer takes the full latch value when the high byte is written.
      if (wr_en && idx == REG_TAHI && !start)
        counter <= {wdata, talo};
      else if (efall && start)
        counter <= (counter == 16'd0) ? {tahi, talo} : counter - 16'd1;

      // A CRA write wins over a one-shot auto-stop on the same edge.
      if (wr_en && idx == REG_CRA) begin
        start   <= wdata[CRA_START_BIT];
        oneshot <= wdata[CRA_ONESHOT_BIT];
      end else if (underflow && oneshot) begin
        start <= 1'b0;
      end

      // Underflow beats the read-to-clear so a coincident event is never lost.
      if (underflow)
        taf <= 1'b1;
      else if (rd_en && idx == REG_ICR)
        taf <= 1'b0;

      if (wr_en && idx == REG_ICR)
        mask <= wdata[ICR_IR_BIT] ? (mask | wdata[ICR_TA_BIT]) : (mask & ~wdata[ICR_TA_BIT]);

      INT_n <= ~(taf & mask);
    end
  end

  // Register read mux for the timer indices; anything else reads zero.
  always_comb begin
    rdata = 8'h00;
    case (idx)
      REG_TALO: rdata = counter[7:0];
      REG_TAHI: rdata = counter[15:8];
      REG_ICR:  rdata = {taf & mask, 6'b000000, taf};
      REG_CRA:  rdata = {4'b0000, oneshot, 2'b00, start};
      default:  rdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/vpa_e_responder.sv
// vpa_e_responder: target side of the 68000 VPA/VMA/E synchronous cycle,
// backing a small 8-bit register file. Define VPA_TIMER_EN to add the timer
// (indices 4,5,13,14 and INT_n); without it those indices are plain scratch.
//
// state  | meaning
// IDLE   | waiting for an address hit
// ASSERT | VPA driven low, waiting for master VMA
// WAITE  | VMA seen, waiting for E high (read data captured on leaving)
// XFER   | E high phase, transfer commits on the E falling edge
// DONE   | VPA released, waiting for AS to rise
module vpa_e_responder
  import tf_bus_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'hBFE,
  parameter bit          LANE      = 1'b1
) (
  input  logic        CLK7M,
  input  logic        RESET,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW00,
  input  logic [23:1] A,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        DOE,
  input  logic        VMA,
  input  logic        E,
  output logic        VPA,
  output logic        INT_n
);

  bus_state_t  state, state_nx;
  logic        e_d, efall, hit;
  logic [3:0]  idx_q;
  logic        rw_q;
  logic        commit, wr_commit, rd_commit;
  logic [7:0]  wr_byte, rd_byte, tmr_rdata;
  logic [7:0]  regs [0:15];
  logic        unused_bits;

  function automatic logic is_scratch(input logic [3:0] idx);
`ifdef VPA_TIMER_EN
    return idx < 4'd4;
`else
    return (idx < 4'd4) || idx == REG_TALO || idx == REG_TAHI ||
           idx == REG_ICR || idx == REG_CRA;
`endif
  endfunction

  assign hit       = ~AS & (A[23:12] == BASE_ADDR) & (LANE ? ~LDS : ~UDS);
  assign efall     = e_d & ~E;
  assign commit    = (state == XFER) & efall & ~AS;
  assign wr_commit = commit & ~rw_q;
  assign rd_commit = commit & rw_q;
  assign wr_byte   = lane_byte(DIN, LANE);
  assign rd_byte   = is_scratch(idx_q) ? regs[idx_q] : tmr_rdata;
  assign unused_bits = ^{A[11:5], DIN};

  // State register, E edge detector and the cycle's latched index/direction.
  always_ff @(posedge CLK7M or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      e_d   <= 1'b0;
      idx_q <= '0;
      rw_q  <= 1'b1;
    end else begin
      state <= state_nx;
      e_d   <= E;
      if (state == IDLE && hit) begin
        idx_q <= A[4:1];
        rw_q  <= RW00;
      end
    end
  end

  // Next-state and bus outputs; an early AS release always aborts to IDLE.
  always_comb begin
    state_nx = state;
    VPA      = 1'b1;
    DOE      = 1'b0;
    case (state)
      IDLE:   if (hit) state_nx = ASSERT;
      ASSERT: begin
        VPA = 1'b0;
        if (AS)        state_nx = IDLE;
        else if (!VMA) state_nx = WAITE;
      end
      WAITE: begin
        VPA = 1'b0;
        DOE = RW00 & ~AS;
        if (AS)     state_nx = IDLE;
        else if (E) state_nx = XFER;
      end
      XFER: begin
        VPA = 1'b0;
        DOE = RW00 & ~AS;
        if (AS)         state_nx = IDLE;
        else if (efall) state_nx = DONE;
      end
      DONE: begin
        DOE = RW00 & ~AS;
        if (AS) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data is sampled as the cycle enters XFER and held through DONE.
  always_ff @(posedge CLK7M or negedge RESET) begin
    if (!RESET)
      DOUT <= '0;
    else if (state == WAITE && !AS && E)
      DOUT <= {rd_byte, rd_byte};
  end

  // Scratch registers; unmapped entries are never written and read as zero.
  always_ff @(posedge CLK7M or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wr_commit && is_scratch(idx_q)) begin
      regs[idx_q] <= wr_byte;
    end
  end

`ifdef VPA_TIMER_EN
  vpa_timer u_timer (
    .CLK7M (CLK7M),
    .RESET (RESET),
    .efall (efall),
    .wr_en (wr_commit),
    .rd_en (rd_commit),
    .idx   (idx_q),
    .wdata (wr_byte),
    .rdata (tmr_rdata),
    .INT_n (INT_n)
  );
`else
  logic unused_rd;
  assign unused_rd = rd_commit;
  assign tmr_rdata = 8'h00;
  assign INT_n     = 1'b1;
`endif

endmodule

// File: tb/tb_vpa_e_responder.sv
// Self-checking bench for vpa_e_responder: table-driven register accesses
// plus hand-written sequences for VMA stalls, aborts, misses, timer and reset.
module tb_vpa_e_responder;

  logic        CLK7M = 1'b0;
  logic        RESET, AS, UDS, LDS, RW00, VMA, E;
  logic [23:1] A;
  logic [15:0] DIN, DOUT;
  logic        DOE, VPA, INT_n;

  int n_checks = 0;
  int n_fail   = 0;

  vpa_e_responder dut (
    .CLK7M (CLK7M), .RESET (RESET), .AS (AS), .UDS (UDS), .LDS (LDS),
    .RW00 (RW00), .A (A), .DIN (DIN), .DOUT (DOUT), .DOE (DOE),
    .VMA (VMA), .E (E), .VPA (VPA), .INT_n (INT_n)
  );

  always #5 CLK7M = ~CLK7M;

  // E: 10 clocks per period, 6 low then 4 high, changing just after a rising edge.
  initial begin
    int e_cnt;
    e_cnt = 0;
    E = 1'b0;
    forever begin
      @(posedge CLK7M);
      #1;
      e_cnt = (e_cnt == 9) ? 0 : e_cnt + 1;
      E = (e_cnt >= 6);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] mk_a(input logic [11:0] hi, input logic [6:0] mid,
                                       input logic [3:0] idx);
    return {hi, mid, idx};
  endfunction

  // One complete E cycle as master: AS, wait VPA, optional VMA stall, then VMA.
  task automatic do_cycle(input logic [22:0] a_in, input logic rw, input logic [7:0] wd,
                          input int vma_hold, output logic [15:0] rd);
    int   n;
    int   hold_bad;
    logic e_p1, e_p2, doe_bad;
    rd = 16'hxxxx;
    @(negedge CLK7M);
    A = a_in; RW00 = rw; DIN = {wd, wd}; AS = 1'b0; LDS = 1'b0; UDS = 1'b1; VMA = 1'b1;
    n = 0;
    while (VPA !== 1'b0 && n < 5) begin @(negedge CLK7M); n++; end
    check("vpa_assert_latency", n, 1);
    hold_bad = 0;
    for (int i = 0; i < vma_hold; i++) begin
      @(negedge CLK7M);
      if (VPA !== 1'b0) hold_bad++;
    end
    if (vma_hold > 0) check("vma_stall_vpa_low", hold_bad, 0);
    VMA = 1'b0;
    e_p1 = E; e_p2 = 1'bx; doe_bad = 1'b0; n = 0;
    while (n < 40) begin
      @(negedge CLK7M);
      n++;
      if (!rw && DOE !== 1'b0) doe_bad = 1'b1;
      if (VPA === 1'b1) break;
      e_p2 = e_p1; e_p1 = E;
    end
    check("vpa_release", VPA, 1);
    check("vpa_release_after_efall", {e_p2, e_p1}, 2'b10);
    if (rw) begin
      check("doe_read", DOE, 1);
      rd = DOUT;
    end else begin
      check("doe_write", doe_bad, 0);
    end
    @(negedge CLK7M);
    AS = 1'b1; LDS = 1'b1; VMA = 1'b1;
    @(negedge CLK7M);
    check("idle_after_cycle_doe", DOE, 0);
  endtask

  task automatic miss(input logic [22:0] a_in, input logic lds, input logic uds, input string name);
    int bad;
    bad = 0;
    @(negedge CLK7M);
    A = a_in; RW00 = 1'b1; AS = 1'b0; LDS = lds; UDS = uds; VMA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK7M);
      if (VPA !== 1'b1 || DOE !== 1'b0) bad++;
    end
    check(name, bad, 0);
    AS = 1'b1; LDS = 1'b1; UDS = 1'b1; VMA = 1'b1;
    @(negedge CLK7M);
  endtask

  typedef struct {
    logic [3:0] idx;
    logic [6:0] mid;
    logic       rw;
    logic [7:0] data;  // write data, or expected read byte
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [15:0] rd;
    int          n, falls;
    logic        prev_e;

    vecs.push_back('{4'd0,  7'h00, 1'b0, 8'h5A});
    vecs.push_back('{4'd0,  7'h00, 1'b1, 8'h5A});
    vecs.push_back('{4'd1,  7'h00, 1'b0, 8'hA5});
    vecs.push_back('{4'd2,  7'h7F, 1'b0, 8'hFF});
    vecs.push_back('{4'd3,  7'h00, 1'b0, 8'h3C});
    vecs.push_back('{4'd1,  7'h00, 1'b1, 8'hA5});
    vecs.push_back('{4'd2,  7'h00, 1'b1, 8'hFF});
    vecs.push_back('{4'd3,  7'h2A, 1'b1, 8'h3C});
    vecs.push_back('{4'd7,  7'h00, 1'b0, 8'h77});
    vecs.push_back('{4'd7,  7'h00, 1'b1, 8'h00});
    vecs.push_back('{4'd15, 7'h00, 1'b0, 8'hEE});
    vecs.push_back('{4'd15, 7'h00, 1'b1, 8'h00});
`ifndef VPA_TIMER_EN
    vecs.push_back('{4'd4,  7'h00, 1'b0, 8'h11});
    vecs.push_back('{4'd5,  7'h00, 1'b0, 8'h22});
    vecs.push_back('{4'd13, 7'h00, 1'b0, 8'h33});
    vecs.push_back('{4'd14, 7'h00, 1'b0, 8'h44});
    vecs.push_back('{4'd4,  7'h00, 1'b1, 8'h11});
    vecs.push_back('{4'd5,  7'h00, 1'b1, 8'h22});
    vecs.push_back('{4'd13, 7'h00, 1'b1, 8'h33});
    vecs.push_back('{4'd14, 7'h00, 1'b1, 8'h44});
`endif

    RESET = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW00 = 1'b1;
    A = '0; DIN = '0; VMA = 1'b1;
    repeat (2) @(negedge CLK7M);
    check("reset_vpa", VPA, 1);
    check("reset_doe", DOE, 0);
    check("reset_dout", DOUT, 16'h0000);
    check("reset_int_n", INT_n, 1);
    RESET = 1'b1;
    repeat (2) @(negedge CLK7M);

    // Register file vectors (first two are the basic write/read-back of 8'h5A).
    foreach (vecs[i]) begin
      do_cycle(mk_a(12'hBFE, vecs[i].mid, vecs[i].idx), vecs[i].rw, vecs[i].data, 0, rd);
      if (vecs[i].rw) check($sformatf("vec%0d_read_idx%0d", i, vecs[i].idx), rd, {vecs[i].data, vecs[i].data});
    end

    // VMA held off for 20 clocks: VPA must stay low, then the write completes.
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd2), 1'b0, 8'h6B, 20, rd);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd2), 1'b1, 8'h00, 0, rd);
    check("vma_stall_write_readback", rd, 16'h6B6B);

    // AS released while waiting for E: abort, no write.
    @(negedge CLK7M);
    A = mk_a(12'hBFE, 7'h00, 4'd0); RW00 = 1'b0; DIN = 16'hC3C3;
    AS = 1'b0; LDS = 1'b0; UDS = 1'b1; VMA = 1'b1;
    n = 0;
    while (VPA !== 1'b0 && n < 5) begin @(negedge CLK7M); n++; end
    n = 0;
    while (E !== 1'b1 && n < 15) begin @(negedge CLK7M); n++; end
    n = 0;
    while (E !== 1'b0 && n < 15) begin @(negedge CLK7M); n++; end
    VMA = 1'b0;
    repeat (2) @(negedge CLK7M);
    check("abort_pre_vpa", VPA, 0);
    AS = 1'b1; LDS = 1'b1;
    @(negedge CLK7M);
    check("abort_vpa", VPA, 1);
    check("abort_doe", DOE, 0);
    VMA = 1'b1;
    repeat (12) @(negedge CLK7M);
    check("abort_vpa_stays_high", VPA, 1);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd0), 1'b1, 8'h00, 0, rd);
    check("abort_no_write", rd, 16'h5A5A);

    // Address and lane misses.
    miss(mk_a(12'hBFD, 7'h00, 4'd0), 1'b0, 1'b1, "miss_base_bfd");
    miss(mk_a(12'hBFE, 7'h00, 4'd0), 1'b1, 1'b0, "miss_lds_high");

`ifdef VPA_TIMER_EN
    // One-shot timer of 2: underflow on the third E fall raises TAF and INT_n.
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd4),  1'b0, 8'h02, 0, rd);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd5),  1'b0, 8'h00, 0, rd);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd13), 1'b0, 8'h81, 0, rd);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd14), 1'b0, 8'h09, 0, rd);
    check("timer_int_idle", INT_n, 1);
    falls = 0; prev_e = E; n = 0;
    while (falls < 2 && n < 60) begin
      @(negedge CLK7M); n++;
      if (prev_e && !E) falls++;
      prev_e = E;
    end
    repeat (2) @(negedge CLK7M);
    check("timer_int_after_2_falls", INT_n, 1);
    prev_e = E; n = 0;
    while (falls < 3 && n < 60) begin
      @(negedge CLK7M); n++;
      if (prev_e && !E) falls++;
      prev_e = E;
    end
    repeat (2) @(negedge CLK7M);
    check("timer_int_after_3_falls", INT_n, 0);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd14), 1'b1, 8'h00, 0, rd);
    check("timer_cra_start_cleared", rd, 16'h0808);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd13), 1'b1, 8'h00, 0, rd);
    check("timer_icr_read1", rd, 16'h8181);
    check("timer_int_cleared", INT_n, 1);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd13), 1'b1, 8'h00, 0, rd);
    check("timer_icr_read2", rd, 16'h0000);
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd4), 1'b1, 8'h00, 0, rd);
    check("timer_reloaded_lo", rd, 16'h0202);
`endif

    // Reset asserted in the middle of a read transfer.
    @(negedge CLK7M);
    A = mk_a(12'hBFE, 7'h00, 4'd0); RW00 = 1'b1; AS = 1'b0; LDS = 1'b0; UDS = 1'b1; VMA = 1'b1;
    n = 0;
    while (VPA !== 1'b0 && n < 5) begin @(negedge CLK7M); n++; end
    VMA = 1'b0;
    @(negedge CLK7M);
    n = 0;
    while (E !== 1'b1 && n < 15) begin @(negedge CLK7M); n++; end
    @(negedge CLK7M);
    check("xfer_pre_vpa", VPA, 0);
    check("xfer_pre_doe", DOE, 1);
    check("xfer_pre_dout", DOUT, 16'h5A5A);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_vpa", VPA, 1);
    check("async_reset_doe", DOE, 0);
    check("async_reset_dout", DOUT, 16'h0000);
    check("async_reset_int_n", INT_n, 1);
    @(negedge CLK7M);
    AS = 1'b1; LDS = 1'b1; VMA = 1'b1;
    @(negedge CLK7M);
    RESET = 1'b1;
    repeat (2) @(negedge CLK7M);
    for (int i = 0; i < 4; i++) begin
      do_cycle(mk_a(12'hBFE, 7'h00, i[3:0]), 1'b1, 8'h00, 0, rd);
      check($sformatf("post_reset_idx%0d", i), rd, 16'h0000);
    end
`ifdef VPA_TIMER_EN
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd14), 1'b1, 8'h00, 0, rd);
    check("post_reset_cra", rd, 16'h0000);
`else
    do_cycle(mk_a(12'hBFE, 7'h00, 4'd13), 1'b1, 8'h00, 0, rd);
    check("post_reset_idx13", rd, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
